beat_rate_meter: RTL

- Sits directly downstream of the hysteresis pulse comparator in the heart-rate path.
- Converts the comparator's `pulse` level into beat events, inter-beat intervals (IBI) in milliseconds, and a heart rate in beats per minute (BPM).
- Rejects physiologically impossible intervals.
- BPM is a rolling 4-interval average computed with an iterative divider.

---
 rtl/beat_rate_meter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/beat_rate_meter.sv
// beat_rate_meter: turns the comparator pulse level into beat strobes, inter-beat
// intervals in ms and a rolling 4-interval average heart rate in BPM.
module beat_rate_meter #(
    parameter int MIN_IBI_MS = 300,
    parameter int MAX_IBI_MS = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        pulse,
    output logic        beat,
    output logic [11:0] ibi_ms,
    output logic [7:0]  bpm,
    output logic        bpm_valid,
    output logic        no_signal
);

    localparam logic [11:0] MIN_CNT   = 12'(MIN_IBI_MS);
    localparam logic [11:0] MAX_CNT   = 12'(MAX_IBI_MS);
    localparam logic [11:0] TMO_CNT   = 12'(MAX_IBI_MS - 1);
    localparam logic [15:0] DIVIDEND  = 16'd60000;
    localparam logic [4:0]  LAST_STEP = 5'd17;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        DIVIDE     = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        pulse_d_r;
    logic        rise_s;
    logic [11:0] cnt_r;
    logic [11:0] hist_r [0:3];
    logic [2:0]  nfill_r;
    logic [2:0]  nfill_inc_s;
    logic [12:0] sum_s;
    logic [15:0] avg_s;
    logic        first_s;
    logic        accept_s;
    logic        timeout_s;
    logic        div_done_s;
    logic [4:0]  div_step_r;
    logic [15:0] rem_r;
    logic [15:0] quo_r;
    logic [15:0] dvsr_r;
    logic [16:0] rem_shift_s;
    logic        sub_neg_s;

    function automatic logic [7:0] sat8(input logic [15:0] v);
        logic [7:0] r;
        if (v[15:8] != 8'd0) begin
            r = 8'hFF;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    assign rise_s      = pulse & ~pulse_d_r;
    assign nfill_inc_s = (nfill_r == 3'd4) ? 3'd4 : (nfill_r + 3'd1);
    assign sum_s       = {1'b0, hist_r[0]} + {1'b0, hist_r[1]}
                       + {1'b0, hist_r[2]} + {1'b0, hist_r[3]};
    assign avg_s       = {3'b000, sum_s} >> 2;
    assign div_done_s  = (state_r == DIVIDE) && (div_step_r == LAST_STEP);
    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_shift_s = {rem_r, quo_r[15]};
    assign sub_neg_s   = (rem_shift_s < {1'b0, dvsr_r});

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= WAIT_FIRST;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and event decode; rise outranks timeout in the same cycle.
    always_comb begin
        next_state_s = state_r;
        first_s      = 1'b0;
        accept_s     = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            WAIT_FIRST: begin
                if (rise_s) begin
                    first_s      = 1'b1;
                    next_state_s = MEASURE;
                end else begin
                    next_state_s = WAIT_FIRST;
                end
            end
            MEASURE: begin
                if (rise_s && (cnt_r >= MIN_CNT)) begin
                    accept_s = 1'b1;
                    if (nfill_inc_s == 3'd4) begin
                        next_state_s = DIVIDE;
                    end else begin
                        next_state_s = MEASURE;
                    end
                end else if (tick && (cnt_r == TMO_CNT)) begin
                    timeout_s    = 1'b1;
                    next_state_s = WAIT_FIRST;
                end else begin
                    next_state_s = MEASURE;
                end
            end
            DIVIDE: begin
                if (div_step_r == LAST_STEP) begin
                    next_state_s = MEASURE;
                end else begin
                    next_state_s = DIVIDE;
                end
            end
            default: begin
                next_state_s = WAIT_FIRST;
            end
        endcase
    end

    // Edge-detect delay register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_d_r <= 1'b0;
        end else begin
            pulse_d_r <= pulse;
        end
    end

    // Interval counter: ms since last accepted edge, saturating at the timeout value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 12'd0;
        end else if (first_s || accept_s) begin
            cnt_r <= 12'd0;
        end else if (tick && (cnt_r < MAX_CNT)) begin
            cnt_r <= cnt_r + 12'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Interval history and fill count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_r[0] <= 12'd0;
            hist_r[1] <= 12'd0;
            hist_r[2] <= 12'd0;
            hist_r[3] <= 12'd0;
            nfill_r   <= 3'd0;
        end else if (accept_s) begin
            hist_r[0] <= cnt_r;
            hist_r[1] <= hist_r[0];
            hist_r[2] <= hist_r[1];
            hist_r[3] <= hist_r[2];
            nfill_r   <= nfill_inc_s;
        end else if (timeout_s) begin
            nfill_r <= 3'd0;
        end else begin
            nfill_r <= nfill_r;
        end
    end

    // Beat strobe, latest interval and loss-of-signal flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat      <= 1'b0;
            ibi_ms    <= 12'd0;
            no_signal <= 1'b1;
        end else begin
            beat <= accept_s;
            if (accept_s) begin
                ibi_ms <= cnt_r;
            end
            if (first_s) begin
                no_signal <= 1'b0;
            end else if (timeout_s) begin
                no_signal <= 1'b1;
            end
        end
    end

    // Divider: step 0 loads, steps 1..16 iterate, step 17 hands the quotient over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_step_r <= 5'd0;
            rem_r      <= 16'd0;
            quo_r      <= 16'd0;
            dvsr_r     <= 16'd0;
        end else if (state_r == DIVIDE) begin
            if (div_step_r == 5'd0) begin
                rem_r  <= 16'd0;
                quo_r  <= DIVIDEND;
                dvsr_r <= avg_s;
            end else if (div_step_r <= 5'd16) begin
                quo_r <= {quo_r[14:0], ~sub_neg_s};
                if (sub_neg_s) begin
                    rem_r <= rem_shift_s[15:0];
                end else begin
                    rem_r <= rem_shift_s[15:0] - dvsr_r;
                end
            end
            div_step_r <= (div_step_r == LAST_STEP) ? 5'd0 : (div_step_r + 5'd1);
        end else begin
            div_step_r <= 5'd0;
        end
    end

    // Rate outputs change only on divide completion or timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bpm       <= 8'd0;
            bpm_valid <= 1'b0;
        end else if (div_done_s) begin
            bpm       <= sat8(quo_r);
            bpm_valid <= 1'b1;
        end else if (timeout_s) begin
            bpm       <= 8'd0;
            bpm_valid <= 1'b0;
        end else begin
            bpm       <= bpm;
            bpm_valid <= bpm_valid;
        end
    end

endmodule
